// File: rtl/i2c_arbiter_if.sv
// i2c_arbiter_if
//   Bundles every non-clock/reset signal of the I2C arbiter: the requester
//   side (req/req_* in, gnt/done/rdata/nack/tmo/grant_id out), the state
//   monitor, and the command interface to the shared I2C master
//   (m_start/m_addr/m_rw/m_wdata/m_abort out, m_busy/m_done/m_rdata/m_nack in).
//   modport master : the arbiter's view (it commands the I2C master).
//   modport slave  : the surrounding logic's view (requesters + I2C master).
interface i2c_arbiter_if #(
  parameter int N_REQ = 4
);
  // requester side
  logic [N_REQ-1:0]   req;
  logic [7*N_REQ-1:0] req_addr;
  logic [N_REQ-1:0]   req_rw;
  logic [8*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic [7:0]         rdata;
  logic               nack;
  logic               tmo;
  logic [2:0]         grant_id;
  logic [1:0]         state;

  // I2C master command side
  logic               m_start;
  logic [6:0]         m_addr;
  logic               m_rw;
  logic [7:0]         m_wdata;
  logic               m_abort;
  logic               m_busy;
  logic               m_done;
  logic [7:0]         m_rdata;
  logic               m_nack;

  modport master (
    input  req, req_addr, req_rw, req_wdata,
    input  m_busy, m_done, m_rdata, m_nack,
    output gnt, done, rdata, nack, tmo, grant_id, state,
    output m_start, m_addr, m_rw, m_wdata, m_abort
  );

  modport slave (
    output req, req_addr, req_rw, req_wdata,
    output m_busy, m_done, m_rdata, m_nack,
    input  gnt, done, rdata, nack, tmo, grant_id, state,
    input  m_start, m_addr, m_rw, m_wdata, m_abort
  );
endinterface

// File: rtl/i2c_arbiter.sv
// i2c_arbiter
//   Round-robin arbiter sharing one I2C master between N_REQ requesters.
//   Each grant latches one single-byte transaction (address, rw, write byte),
//   launches it on the master, waits for m_done or a timeout, then pulses
//   done to the granted requester with rdata/nack/tmo.
// Ports:
//   clk  - system clock, all state on the rising edge
//   rst  - asynchronous active-low reset
//   bus  - i2c_arbiter_if.master: requester handshake, state monitor and
//          I2C master command interface
// Parameters:
//   N_REQ   - number of requesters (2..8)
//   TIMEOUT - max cycles spent in WAIT before abort; 0 disables the timeout
module i2c_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  i2c_arbiter_if.master   bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [2:0]    LAST_INIT = 3'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT     = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [2:0]       last_reg;
  logic [2:0]       grant_id_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic [N_REQ-1:0] done_reg;
  logic [7:0]       rdata_reg;
  logic             nack_reg;
  logic             tmo_reg;
  logic [6:0]       m_addr_reg;
  logic             m_rw_reg;
  logic [7:0]       m_wdata_reg;
  logic             m_abort_reg;
  logic [CW-1:0]    cnt_reg;

  // Unpacked per-requester views of the packed request fields
  logic [6:0]       addr_arr  [N_REQ];
  logic             rw_arr    [N_REQ];
  logic [7:0]       wdata_arr [N_REQ];

  logic             sel_valid;
  logic [2:0]       sel_idx;
  logic [IW-1:0]    cand_idx;
  int               cand;
  logic [N_REQ-1:0] sel_onehot;
  logic [N_REQ-1:0] done_onehot;
  logic             timeout_hit;
  logic             m_start_c;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign addr_arr[gi]    = bus.req_addr[7*gi +: 7];
      assign rw_arr[gi]      = bus.req_rw[gi];
      assign wdata_arr[gi]   = bus.req_wdata[8*gi +: 8];
      assign sel_onehot[gi]  = sel_valid && (sel_idx == 3'(gi));
      assign done_onehot[gi] = (grant_id_reg == 3'(gi));
    end
  endgenerate

  // Search last+1, last+2, ... (mod N_REQ); the first pending request wins,
  // so the requester served most recently has the lowest priority.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand     = (int'(last_reg) + k) % N_REQ;
      cand_idx = IW'(cand);
      if (!sel_valid && bus.req[cand_idx]) begin
        sel_valid = 1'b1;
        sel_idx   = 3'(cand);
      end
    end
  end

  // The counter is only cleared on WAIT entry, so its value is meaningful
  // only while in WAIT.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    m_start_c  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sel_valid) state_next = ISSUE;
      end
      ISSUE: begin
        // Hold here while the master is busy; no timeout applies in ISSUE.
        m_start_c = !bus.m_busy;
        if (!bus.m_busy) state_next = WAIT;
      end
      WAIT: begin
        if (bus.m_done || timeout_hit) state_next = COMPLETE;
      end
      COMPLETE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_reg     <= LAST_INIT;
      grant_id_reg <= '0;
      gnt_reg      <= '0;
      done_reg     <= '0;
      rdata_reg    <= '0;
      nack_reg     <= 1'b0;
      tmo_reg      <= 1'b0;
      m_addr_reg   <= '0;
      m_rw_reg     <= 1'b0;
      m_wdata_reg  <= '0;
      m_abort_reg  <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      gnt_reg     <= '0;
      done_reg    <= '0;
      m_abort_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sel_valid) begin
            m_addr_reg   <= addr_arr[sel_idx[IW-1:0]];
            m_rw_reg     <= rw_arr[sel_idx[IW-1:0]];
            m_wdata_reg  <= wdata_arr[sel_idx[IW-1:0]];
            grant_id_reg <= sel_idx;
            gnt_reg      <= sel_onehot;
          end
        end
        ISSUE: begin
          if (!bus.m_busy) cnt_reg <= '0;
        end
        WAIT: begin
          if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
          // m_done takes precedence over a coincident timeout
          if (bus.m_done) begin
            rdata_reg <= bus.m_rdata;
            nack_reg  <= bus.m_nack;
            tmo_reg   <= 1'b0;
            done_reg  <= done_onehot;
          end else if (timeout_hit) begin
            m_abort_reg <= 1'b1;
            tmo_reg     <= 1'b1;
            nack_reg    <= 1'b0;
            done_reg    <= done_onehot;
          end
        end
        COMPLETE: begin
          last_reg <= grant_id_reg;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt      = gnt_reg;
  assign bus.done     = done_reg;
  assign bus.rdata    = rdata_reg;
  assign bus.nack     = nack_reg;
  assign bus.tmo      = tmo_reg;
  assign bus.grant_id = grant_id_reg;
  assign bus.state    = state_reg;
  assign bus.m_start  = m_start_c;
  assign bus.m_addr   = m_addr_reg;
  assign bus.m_rw     = m_rw_reg;
  assign bus.m_wdata  = m_wdata_reg;
  assign bus.m_abort  = m_abort_reg;

endmodule
